// File: rtl/verilog_bm_123_146.sv
// Priority patient queue: each clock edge either enqueues one 4-bit record or dequeues the
// most urgent one, with ties going to the earliest arrival.
module verilog_bm_123_146 #(
  parameter int DEPTH = 8
) (
  input  logic [3:0] in,
  input  logic       clk,
  output logic [3:0] out,
  input  logic       ende,
  output logic [3:0] counter,
  input  logic       rst
);

  localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DEPTH4 = 4'(DEPTH);

  // Slots [0, counter) are occupied and kept in arrival order, so slot 0 is always the oldest.
  // Compacting on every removal makes slot position the arrival tag, and that tag cannot wrap.
  logic [3:0]       slots [DEPTH];
  logic [IDX_W-1:0] sel_idx;
  logic [1:0]       best_pri;
  logic             found;
  logic             do_enq;
  logic             do_deq;

  assign do_enq = !ende && (counter < DEPTH4);
  assign do_deq = ende && (counter != 4'd0);

  // A strict '>' keeps the lowest index among equal priorities, which is the FIFO tie-break.
  always_comb begin
    found    = 1'b0;
    best_pri = 2'd0;
    sel_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((4'(i) < counter) && (!found || (slots[i][3:2] > best_pri))) begin
        found    = 1'b1;
        best_pri = slots[i][3:2];
        sel_idx  = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter <= 4'd0;
      out     <= 4'd0;
    end else if (do_deq) begin
      out     <= slots[sel_idx];
      counter <= counter - 4'd1;
    end else if (do_enq) begin
      counter <= counter + 4'd1;
    end
  end

  // NOTE: the slot array has no reset. Occupancy is defined only by counter, so clearing
  // counter empties the queue. Stale data in a slot is never selected.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (do_deq) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (i >= int'(sel_idx)) slots[i] <= slots[i+1];
        end
      end else if (do_enq) begin
        slots[counter[IDX_W-1:0]] <= in;
      end
    end
  end

endmodule

// File: tb/tb_verilog_bm_123_146.sv
// Self-checking bench for the priority patient queue. It runs the directed scenarios first,
// then random traffic checked against a queue-based reference model.
module tb_verilog_bm_123_146;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in;
  logic       ende;
  logic [3:0] out;
  logic [3:0] counter;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] model_q [$];
  logic [3:0] model_out;

  verilog_bm_123_146 #(.DEPTH(DEPTH)) dut (
    .in(in), .clk(clk), .out(out), .ende(ende), .counter(counter), .rst(rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: records are kept in arrival order. A dequeue takes the first record
  // with the highest priority.
  task automatic model_op(input logic e, input logic [3:0] d);
    int idx;
    if (!e) begin
      if (model_q.size() < DEPTH) model_q.push_back(d);
    end else if (model_q.size() > 0) begin
      idx = 0;
      for (int i = 1; i < model_q.size(); i++)
        if (model_q[i][3:2] > model_q[idx][3:2]) idx = i;
      model_out = model_q[idx];
      model_q.delete(idx);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] d);
    ende = e;
    in   = d;
    @(posedge clk);
    #1;
    model_op(e, d);
    check(e ? "deq_out" : "enq_out", out, model_out);
    check("counter", counter, 4'(model_q.size()));
    // Garbage between edges must have no effect on the DUT.
    in = 4'($urandom);
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    model_out = 4'd0;
    check("rst_out", out, 4'd0);
    check("rst_cnt", counter, 4'd0);
    @(posedge clk);
    #1;
    check("rst_hold", counter, 4'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    in   = 4'd0;
    ende = 1'b0;
    model_out = 4'd0;
    #2;
    check("init_out", out, 4'd0);
    check("init_cnt", counter, 4'd0);
    @(negedge clk);
    rst = 1'b0;

    step(0, 4'b0011); step(0, 4'b1010); step(1, 4'bx000);
    check("s1_out", out, 4'b1010);
    step(0, 4'b1101); step(1, 4'd0);
    check("s1b_out", out, 4'b1101);
    step(1, 4'd0);

    do_reset();
    step(0, 4'b0100); step(0, 4'b0101); step(0, 4'b0110);
    step(1, 4'd0); check("fifo0", out, 4'b0100);
    step(1, 4'd0); check("fifo1", out, 4'b0101);
    step(1, 4'd0); check("fifo2", out, 4'b0110);

    do_reset();
    for (int i = 0; i < 8; i++) step(0, 4'(i));
    step(0, 4'b1111);
    check("full_cnt", counter, 4'b1000);
    for (int i = 0; i < 8; i++) begin
      step(1, 4'd0);
      if (out == 4'b1111) check("ninth_seen", out, 4'b0000);
    end

    do_reset();
    step(1, 4'd0);
    check("empty_out", out, 4'd0);
    step(0, 4'b1000); step(1, 4'd0);
    check("one_out", out, 4'b1000);
    step(1, 4'd0);
    check("hold_out", out, 4'b1000);

    step(0, 4'b0001); step(0, 4'b1110); step(0, 4'b0111);
    do_reset();
    step(1, 4'd0);
    check("post_rst_out", out, 4'd0);

    step(0, 4'b1100); step(0, 4'b0001); step(1, 4'd0);
    check("il0", out, 4'b1100);
    step(0, 4'b1110); step(0, 4'b1111); step(1, 4'd0);
    check("il1", out, 4'b1110);
    step(1, 4'd0); check("il2", out, 4'b1111);
    step(1, 4'd0); check("il3", out, 4'b0001);
    check("il_cnt", counter, 4'd0);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      step(1'($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 60)), 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/verilog_bm_123_146.md
VERILOG_BM_123_146 -- requirements
Module: verilog_bm_123_146

Interface
REQ-001 Parameter DEPTH, default 8, meaning patient-slot capacity of the queue; legal range 1..15.
REQ-002 Port clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-003 Port rst  input  1  reset; asynchronous, active-high.
REQ-004 Port in  input  4  patient record: in[3:2] = priority, in[1:0] = patient ID.
REQ-005 Port clk, rst, in, out, ende, counter positional order SHALL be in, clk, out, ende, counter; rst is connected by name.
REQ-006 Port out  output  4  most recently dequeued record, {priority, ID}; registered.
REQ-007 Port ende  input  1  operation select: 0 = enqueue, 1 = dequeue.
REQ-008 Port counter  output  4  number of patients currently stored (0..DEPTH); registered.

Function
REQ-009 The block SHALL store up to DEPTH 4-bit records together with an arrival-order tag.
REQ-010 Exactly one operation SHALL be evaluated per rising clk edge: enqueue when ende=0, dequeue when ende=1; there is no separate valid strobe.
REQ-011 Enqueue with counter<DEPTH SHALL store in and increment counter by 1 at that edge.
REQ-012 Enqueue with counter==DEPTH (full) SHALL be ignored: no record stored, counter and out unchanged.
REQ-013 Dequeue with counter>0 SHALL select the stored record with the numerically highest priority (3 most urgent, 0 least).
REQ-014 Among records of equal highest priority, the one enqueued earliest SHALL be selected (FIFO tie-break).
REQ-015 On dequeue the selected record SHALL be loaded into out, removed from storage, and counter decremented by 1, all at the same edge.
REQ-016 Dequeue with counter==0 (empty) SHALL be ignored: out and counter hold their previous values.
REQ-017 out SHALL hold its value across enqueue cycles and ignored operations; it changes only on a successful dequeue or reset.
REQ-018 Selection SHALL consider only occupied slots; stale contents of freed slots SHALL never be output.
REQ-019 Arrival-order tags SHALL remain correctly ordered across arbitrarily long runs (no wrap-around mis-ordering); e.g. compact storage on removal or use tags wider than log2(DEPTH)+1 with relative compare.
REQ-020 counter SHALL never exceed DEPTH nor underflow below 0.
REQ-021 Input in is sampled only at the rising edge; changes between edges have no effect.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for clk, clear counter to 0, out to 4'b0000, and mark all slots empty.
REQ-023 While rst=1, clock edges SHALL have no effect; operation resumes at the first rising edge after rst deasserts.
REQ-024 Reset asserted mid-operation SHALL discard all stored patients; a following dequeue is treated as empty.

Verification
REQ-025 Reset, then enqueue 0011, enqueue 1010, dequeue -> out=1010, counter 1,2,1; then enqueue 1101, dequeue -> out=1101, counter 2,1.
REQ-026 Enqueue 0100, 0101, 0110 (all priority 01), dequeue three times -> out 0100, 0101, 0110 in that order, counter 3,2,1,0.
REQ-027 Enqueue 9 records with DEPTH=8 -> counter saturates at 8 (4'b1000); ninth record (e.g. 1111) never appears in out on the 8 subsequent dequeues.
REQ-028 From reset, dequeue with empty queue -> out=0000, counter=0; enqueue 1000, dequeue -> out=1000; further dequeue -> out stays 1000, counter stays 0.
REQ-029 Enqueue 0001, 1110, 0111, assert rst asynchronously between edges -> counter=0 and out=0000 before the next edge; subsequent dequeue leaves both at 0.
REQ-030 Interleaved enqueue 1100, enqueue 0001, dequeue (out=1100), enqueue 1110, enqueue 1111, dequeue (out=1110), dequeue (out=1111), dequeue (out=0001) -> counter ends at 0.
